// File: rtl/rpn_char_arbiter.sv
// rpn_char_arbiter: shares the RPN ALU character port between two requesters.
// A requester keeps the lock from its first character through '=' and until it
// accepts its result. Ties between expressions are broken round-robin.
// Optional build macro: RPN_ARB_FILTER_EN drops owner characters that are not
// digits, '+', '-', '*', '/' or '='. Dropped characters are still acknowledged.
module rpn_char_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0_STB,
  input  logic [7:0] REQ0_CHAR,
  output logic       REQ0_ACK,
  input  logic       REQ1_STB,
  input  logic [7:0] REQ1_CHAR,
  output logic       REQ1_ACK,
  output logic       RES0_STB,
  output logic       RES1_STB,
  output logic [7:0] RES_CHAR,
  input  logic       RES0_ACK,
  input  logic       RES1_ACK,
  output logic       ALU_IN_STB,
  output logic [7:0] ALU_IN_CHAR,
  input  logic       ALU_IN_ACK,
  input  logic       ALU_OUT_STB,
  input  logic [7:0] ALU_OUT_CHAR,
  output logic       ALU_OUT_ACK,
  output logic       BUSY,
  output logic       OWNER,
  output logic       ABORT
);

  localparam int unsigned CHAR_W = 8;
  localparam logic [CHAR_W-1:0] CHAR_EQ = 8'h3d;
  localparam logic [TO_W-1:0]   TO_MAX  = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_RESULT
  } state_t;

  state_t            state, state_d;
  logic              last_grant, last_grant_d;
  logic [TO_W-1:0]   tcnt, tcnt_d, tcnt_inc;
  logic              owner_d;
  logic              req0_ack_d, req1_ack_d;
  logic              res0_stb_d, res1_stb_d;
  logic [CHAR_W-1:0] res_char_d;
  logic              alu_in_stb_d;
  logic [CHAR_W-1:0] alu_in_char_d;
  logic              alu_out_ack_d;
  logic              abort_d;
  logic              busy_d;

  logic              owner_stb;
  logic [CHAR_W-1:0] owner_char;
  logic              owner_res_ack;
  logic              fwd;

  // Current owner's request, character and result acknowledge
  assign owner_stb     = OWNER ? REQ1_STB  : REQ0_STB;
  assign owner_char    = OWNER ? REQ1_CHAR : REQ0_CHAR;
  assign owner_res_ack = OWNER ? RES1_ACK  : RES0_ACK;

  // Idle counter steps up but sticks at its limit
  assign tcnt_inc = (tcnt == TO_MAX) ? tcnt : tcnt + TO_W'(1);

`ifdef RPN_ARB_FILTER_EN
  function automatic logic char_allowed(input logic [CHAR_W-1:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || (c == 8'h2b) || (c == 8'h2d) ||
           (c == 8'h2a) || (c == 8'h2f) || (c == CHAR_EQ);
  endfunction
  assign fwd = char_allowed(owner_char);
`else
  assign fwd = 1'b1;
`endif

  // State and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      tcnt        <= '0;
      OWNER       <= 1'b0;
      REQ0_ACK    <= 1'b0;
      REQ1_ACK    <= 1'b0;
      RES0_STB    <= 1'b0;
      RES1_STB    <= 1'b0;
      RES_CHAR    <= '0;
      ALU_IN_STB  <= 1'b0;
      ALU_IN_CHAR <= '0;
      ALU_OUT_ACK <= 1'b0;
      BUSY        <= 1'b0;
      ABORT       <= 1'b0;
    end else begin
      state       <= state_d;
      last_grant  <= last_grant_d;
      tcnt        <= tcnt_d;
      OWNER       <= owner_d;
      REQ0_ACK    <= req0_ack_d;
      REQ1_ACK    <= req1_ack_d;
      RES0_STB    <= res0_stb_d;
      RES1_STB    <= res1_stb_d;
      RES_CHAR    <= res_char_d;
      ALU_IN_STB  <= alu_in_stb_d;
      ALU_IN_CHAR <= alu_in_char_d;
      ALU_OUT_ACK <= alu_out_ack_d;
      BUSY        <= busy_d;
      ABORT       <= abort_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d       = state;
    last_grant_d  = last_grant;
    tcnt_d        = tcnt;
    owner_d       = OWNER;
    req0_ack_d    = 1'b0;
    req1_ack_d    = 1'b0;
    res0_stb_d    = RES0_STB;
    res1_stb_d    = RES1_STB;
    res_char_d    = RES_CHAR;
    alu_in_stb_d  = ALU_IN_STB;
    alu_in_char_d = ALU_IN_CHAR;
    alu_out_ack_d = 1'b0;
    abort_d       = 1'b0;

    case (state)
      S_IDLE: begin
        if (REQ0_STB || REQ1_STB) begin
          owner_d = (REQ0_STB && REQ1_STB) ? ~last_grant : REQ1_STB;
          tcnt_d  = '0;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        if (owner_stb) begin
          tcnt_d = '0;
          if (OWNER) req1_ack_d = 1'b1;
          else       req0_ack_d = 1'b1;
          if (fwd) begin
            alu_in_char_d = owner_char;
            alu_in_stb_d  = 1'b1;
            state_d       = S_SEND;
          end
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TO_MAX) begin
            abort_d      = 1'b1;
            last_grant_d = OWNER;
            state_d      = S_IDLE;
          end
        end
      end

      S_SEND: begin
        if (ALU_IN_ACK) begin
          alu_in_stb_d = 1'b0;
          state_d      = (ALU_IN_CHAR == CHAR_EQ) ? S_RESULT : S_GRANT;
        end
      end

      S_RESULT: begin
        if (!RES0_STB && !RES1_STB) begin
          if (ALU_OUT_STB) begin
            res_char_d = ALU_OUT_CHAR;
            if (OWNER) res1_stb_d = 1'b1;
            else       res0_stb_d = 1'b1;
          end
        end else if (owner_res_ack) begin
          res0_stb_d    = 1'b0;
          res1_stb_d    = 1'b0;
          alu_out_ack_d = 1'b1;
          last_grant_d  = OWNER;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule
